// File: rtl/trigger_pkg.sv
// Purpose: shared state encodings and default pulse/timeout constants for pulse-trigger blocks.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package trigger_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    localparam int DEF_PULSE_LEN = 4;
    localparam int DEF_TIMEOUT   = 255;
    // Wide enough for any TIMEOUT in 1..255 and any PULSE_LEN in 1..15.
    localparam int CNT_W         = 8;

endpackage

// File: rtl/trigger_scheduler_if.sv
// Purpose: bundles the request inputs, resource done strobe and grant/status outputs of the scheduler.
// Latency: n/a (wiring only).
// Backpressure: none; the resource throttles the scheduler through res_done or the timeout.
interface trigger_scheduler_if #(
    parameter int N_REQ = 4
) ();
    localparam int IDW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [N_REQ-1:0] req_in;
    logic             res_done;
    logic             trigger_out;
    logic             grant_valid;
    logic [IDW-1:0]   grant_id;
    logic [N_REQ-1:0] pending;
    logic             overrun;
    logic             timeout_err;
    logic             debug_out;

    // Scheduler side.
    modport slave (
        input  req_in, res_done,
        output trigger_out, grant_valid, grant_id, pending, overrun, timeout_err, debug_out
    );

    // Requesters plus shared resource side.
    modport master (
        output req_in, res_done,
        input  trigger_out, grant_valid, grant_id, pending, overrun, timeout_err, debug_out
    );
endinterface

// File: rtl/edge_sync.sv
// Purpose: synchronises one asynchronous request level and flags its rising edge.
// Latency: rise is a registered one-cycle pulse SYNC_STAGES+1 cycles after req_in rises.
// Backpressure: none; every edge is reported, the consumer decides what to keep.
module edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_core,
    input  logic reset,
    input  logic req_in,
    output logic rise
);
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   hist_q, hist_d;
    logic                   rise_q, rise_d;

    // Shift the level through the synchroniser, keep one cycle of history, compare.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], req_in};
        hist_d = sync_q[SYNC_STAGES-1];
        rise_d = sync_q[SYNC_STAGES-1] & ~hist_q;
    end

    // Synchroniser, history and rise registers.
    always_ff @(posedge clk_core or negedge reset) begin
        if (!reset) begin
            sync_q <= '0;
            hist_q <= 1'b0;
            rise_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            hist_q <= hist_d;
            rise_q <= rise_d;
        end
    end

    assign rise = rise_q;
endmodule

// File: rtl/trigger_scheduler.sv
// Purpose: round-robin arbiter turning request edges into fixed-width pulses on one shared resource.
// Latency: pending visible in IDLE at t -> trigger_out high t+1..t+PULSE_LEN; min pulse period PULSE_LEN+2.
// Backpressure: one grant in flight; next grant waits for res_done or TIMEOUT, requests stay sticky meanwhile.
module trigger_scheduler
    import trigger_pkg::*;
#(
    parameter int N_REQ       = 4,
    parameter int PULSE_LEN   = DEF_PULSE_LEN,
    parameter int TIMEOUT     = DEF_TIMEOUT,
    parameter int SYNC_STAGES = 2
) (
    input logic             clk_core,
    input logic             reset,
    trigger_scheduler_if.slave bus
);
    localparam int IDW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [N_REQ-1:0] rise;
    logic [N_REQ-1:0] clr;
    logic [IDW-1:0]   sel;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             trigger_q, trigger_d;
    logic             grant_valid_q, grant_valid_d;
    logic [IDW-1:0]   grant_id_q, grant_id_d;
    logic [IDW-1:0]   last_grant_q, last_grant_d;
    logic [N_REQ-1:0] pending_q, pending_d;
    logic             overrun_q, overrun_d;
    logic             timeout_err_q, timeout_err_d;
    logic             done_seen_q, done_seen_d;

    for (genvar i = 0; i < N_REQ; i++) begin : g_sync
        edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_edge_sync (
            .clk_core (clk_core),
            .reset    (reset),
            .req_in   (bus.req_in[i]),
            .rise     (rise[i])
        );
    end

    // First pending requester after the last one served, wrapping around.
    function automatic logic [IDW-1:0] rr_pick(input logic [N_REQ-1:0] req,
                                               input logic [IDW-1:0]   last);
        logic [IDW-1:0] pick;
        logic [IDW-1:0] idx;
        logic           found;
        pick  = last;
        found = 1'b0;
        for (int k = 1; k <= N_REQ; k++) begin
            idx = IDW'((int'(last) + k) % N_REQ);
            if (!found && req[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    // Grant FSM, pulse/wait counter, and sticky pending bookkeeping.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        trigger_d     = trigger_q;
        grant_valid_d = grant_valid_q;
        grant_id_d    = grant_id_q;
        last_grant_d  = last_grant_q;
        done_seen_d   = done_seen_q;
        timeout_err_d = 1'b0;
        clr           = '0;
        sel           = rr_pick(pending_q, last_grant_q);

        case (state_q)
            IDLE: begin
                done_seen_d = 1'b0;
                if (|pending_q) begin
                    grant_id_d    = sel;
                    last_grant_d  = sel;
                    clr           = N_REQ'(1) << sel;
                    grant_valid_d = 1'b1;
                    trigger_d     = 1'b1;
                    cnt_d         = '0;
                    state_d       = PULSE;
                end
            end
            PULSE: begin
                // An early done is remembered so WAIT can leave on its first cycle.
                if (bus.res_done) begin
                    done_seen_d = 1'b1;
                end
                if (cnt_q == CNT_W'(PULSE_LEN - 1)) begin
                    trigger_d = 1'b0;
                    cnt_d     = '0;
                    state_d   = WAIT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            WAIT: begin
                if (bus.res_done || done_seen_q) begin
                    state_d       = IDLE;
                    grant_valid_d = 1'b0;
                    done_seen_d   = 1'b0;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    timeout_err_d = 1'b1;
                    state_d       = IDLE;
                    grant_valid_d = 1'b0;
                    done_seen_d   = 1'b0;
                    cnt_d         = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d       = IDLE;
                trigger_d     = 1'b0;
                grant_valid_d = 1'b0;
            end
        endcase

        // A new edge beats a grant's clear on the same bit and is then not an overrun.
        pending_d = (pending_q & ~clr) | rise;
        overrun_d = |(rise & pending_q & ~clr);
    end

    // State and output registers.
    always_ff @(posedge clk_core or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            trigger_q     <= 1'b0;
            grant_valid_q <= 1'b0;
            grant_id_q    <= '0;
            last_grant_q  <= IDW'(N_REQ - 1);
            pending_q     <= '0;
            overrun_q     <= 1'b0;
            timeout_err_q <= 1'b0;
            done_seen_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            trigger_q     <= trigger_d;
            grant_valid_q <= grant_valid_d;
            grant_id_q    <= grant_id_d;
            last_grant_q  <= last_grant_d;
            pending_q     <= pending_d;
            overrun_q     <= overrun_d;
            timeout_err_q <= timeout_err_d;
            done_seen_q   <= done_seen_d;
        end
    end

    assign bus.trigger_out = trigger_q;
    assign bus.debug_out   = trigger_q;
    assign bus.grant_valid = grant_valid_q;
    assign bus.grant_id    = grant_id_q;
    assign bus.pending     = pending_q;
    assign bus.overrun     = overrun_q;
    assign bus.timeout_err = timeout_err_q;
endmodule

// File: tb/tb_trigger_scheduler.sv
// Purpose: directed self-checking bench for trigger_scheduler (N_REQ=4, PULSE_LEN=4, TIMEOUT=10).
// Latency: outputs sampled 1 time unit after each rising clock edge.
// Backpressure: res_done driven by the bench; every wait is bounded.
module tb_trigger_scheduler;
    localparam int N_REQ     = 4;
    localparam int PULSE_LEN = 4;
    localparam int TIMEOUT   = 10;

    logic clk_core;
    logic reset;
    int   checks;
    int   errors;

    trigger_scheduler_if #(.N_REQ(N_REQ)) bus ();

    trigger_scheduler #(
        .N_REQ       (N_REQ),
        .PULSE_LEN   (PULSE_LEN),
        .TIMEOUT     (TIMEOUT),
        .SYNC_STAGES (2)
    ) dut (
        .clk_core (clk_core),
        .reset    (reset),
        .bus      (bus)
    );

    initial clk_core = 1'b0;
    always #5 clk_core = ~clk_core;

    typedef struct {
        logic [3:0]  req;
        logic        done;
        logic [10:0] exp;
    } vec_t;

    vec_t vt[13];

    // Packed view {trigger, debug, grant_valid, grant_id, pending, overrun, timeout_err}.
    function automatic logic [10:0] mk(input logic t, input logic g, input logic [1:0] id,
                                       input logic [3:0] p, input logic o, input logic to);
        return {t, t, g, id, p, o, to};
    endfunction

    function automatic logic [10:0] obs();
        return {bus.trigger_out, bus.debug_out, bus.grant_valid, bus.grant_id,
                bus.pending, bus.overrun, bus.timeout_err};
    endfunction

    task automatic tick();
        @(posedge clk_core);
        #1;
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic reset_dut(input logic [3:0] req_at_release);
        reset        = 1'b0;
        bus.res_done = 1'b0;
        repeat (2) tick();
        bus.req_in = req_at_release;
        reset      = 1'b1;
    endtask

    // Follows one whole grant: pulse width, id, then res_done after done_delay WAIT cycles.
    task automatic do_grant(input string nm, input int exp_id, input int done_delay);
        int n;
        int hi;
        n = 0;
        while (!bus.trigger_out && n < 100) begin
            tick();
            n++;
        end
        check({nm, "_seen"}, 32'(bus.trigger_out), 32'd1);
        check({nm, "_id"}, 32'(bus.grant_id), 32'(exp_id));
        hi = 0;
        while (bus.trigger_out && hi < 50) begin
            hi++;
            tick();
        end
        check({nm, "_width"}, 32'(hi), 32'(PULSE_LEN));
        repeat (done_delay) tick();
        bus.res_done = 1'b1;
        tick();
        bus.res_done = 1'b0;
        check({nm, "_release"}, 32'(bus.grant_valid), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int hi;
        checks = 0;
        errors = 0;

        // Single request on requester 2, res_done three cycles into WAIT.
        vt[0]  = '{req: 4'b0100, done: 1'b0, exp: mk(1'b0, 1'b0, 2'd0, 4'b0000, 1'b0, 1'b0)};
        vt[1]  = '{req: 4'b0100, done: 1'b0, exp: mk(1'b0, 1'b0, 2'd0, 4'b0000, 1'b0, 1'b0)};
        vt[2]  = '{req: 4'b0100, done: 1'b0, exp: mk(1'b0, 1'b0, 2'd0, 4'b0000, 1'b0, 1'b0)};
        vt[3]  = '{req: 4'b0100, done: 1'b0, exp: mk(1'b0, 1'b0, 2'd0, 4'b0100, 1'b0, 1'b0)};
        vt[4]  = '{req: 4'b0100, done: 1'b0, exp: mk(1'b1, 1'b1, 2'd2, 4'b0000, 1'b0, 1'b0)};
        vt[5]  = '{req: 4'b0100, done: 1'b0, exp: mk(1'b1, 1'b1, 2'd2, 4'b0000, 1'b0, 1'b0)};
        vt[6]  = '{req: 4'b0100, done: 1'b0, exp: mk(1'b1, 1'b1, 2'd2, 4'b0000, 1'b0, 1'b0)};
        vt[7]  = '{req: 4'b0100, done: 1'b0, exp: mk(1'b1, 1'b1, 2'd2, 4'b0000, 1'b0, 1'b0)};
        vt[8]  = '{req: 4'b0100, done: 1'b0, exp: mk(1'b0, 1'b1, 2'd2, 4'b0000, 1'b0, 1'b0)};
        vt[9]  = '{req: 4'b0100, done: 1'b0, exp: mk(1'b0, 1'b1, 2'd2, 4'b0000, 1'b0, 1'b0)};
        vt[10] = '{req: 4'b0100, done: 1'b0, exp: mk(1'b0, 1'b1, 2'd2, 4'b0000, 1'b0, 1'b0)};
        vt[11] = '{req: 4'b0100, done: 1'b1, exp: mk(1'b0, 1'b0, 2'd2, 4'b0000, 1'b0, 1'b0)};
        vt[12] = '{req: 4'b0100, done: 1'b0, exp: mk(1'b0, 1'b0, 2'd2, 4'b0000, 1'b0, 1'b0)};

        reset        = 1'b0;
        bus.req_in   = '0;
        bus.res_done = 1'b0;
        tick();
        tick();
        check("reset_state", 32'(obs()), 32'd0);
        reset = 1'b1;

        for (int i = 0; i < 13; i++) begin
            bus.req_in   = vt[i].req;
            bus.res_done = vt[i].done;
            tick();
            check($sformatf("vec%0d", i), 32'(obs()), 32'(vt[i].exp));
        end
        bus.res_done = 1'b0;

        // Fairness: all rise together, served 0,1,2,3; a fresh rise on 0 during grant 3 comes next.
        reset_dut(4'b0000);
        bus.req_in = 4'b1111;
        do_grant("rr0", 0, 2);
        do_grant("rr1", 1, 2);
        bus.req_in = 4'b1110;
        do_grant("rr2", 2, 2);
        bus.req_in = 4'b1111;
        do_grant("rr3", 3, 2);
        do_grant("rr0b", 0, 2);

        // Timeout: no res_done, timeout_err 10 cycles after WAIT entry, then next pending served.
        reset_dut(4'b0000);
        bus.req_in = 4'b0010;
        n = 0;
        while (!bus.trigger_out && n < 100) begin
            tick();
            n++;
        end
        check("to_id", 32'(bus.grant_id), 32'd1);
        bus.req_in = 4'b1010;
        hi = 0;
        while (bus.trigger_out && hi < 50) begin
            hi++;
            tick();
        end
        n = 0;
        while (!bus.timeout_err && n < 50) begin
            tick();
            n++;
        end
        check("to_delay", 32'(n), 32'(TIMEOUT));
        check("to_gv", 32'(bus.grant_valid), 32'd0);
        check("to_pending", 32'(bus.pending), 32'b1000);
        tick();
        check("to_single", 32'(bus.timeout_err), 32'd0);
        check("to_next_trig", 32'(bus.trigger_out), 32'd1);
        check("to_next_id", 32'(bus.grant_id), 32'd3);

        // Overrun: second rise on 1 while pending, exactly one overrun and one grant.
        reset_dut(4'b0000);
        bus.req_in = 4'b0001;
        repeat (5) tick();
        check("ovr_busy", 32'(bus.grant_id), 32'd0);
        bus.req_in = 4'b0011;
        repeat (4) tick();
        check("ovr_pend", 32'(bus.pending), 32'b0010);
        bus.req_in = 4'b0001;
        repeat (3) tick();
        bus.req_in = 4'b0011;
        n = 0;
        repeat (5) begin
            tick();
            if (bus.overrun) n++;
        end
        check("ovr_count", 32'(n), 32'd1);
        check("ovr_pend_kept", 32'(bus.pending), 32'b0010);
        bus.res_done = 1'b1;
        tick();
        bus.res_done = 1'b0;
        do_grant("ovr_g", 1, 1);
        n = 0;
        repeat (15) begin
            tick();
            if (bus.trigger_out) n++;
        end
        check("ovr_one_grant", 32'(n), 32'd0);
        check("ovr_pend_empty", 32'(bus.pending), 32'd0);

        // Rise on requester 2 in the very cycle it is granted: pending re-set, no overrun.
        reset_dut(4'b0000);
        bus.req_in = 4'b0001;
        bus.req_in = 4'b0101;
        repeat (5) tick();
        bus.req_in = 4'b0001;
        repeat (4) tick();
        check("gc_pend", 32'(bus.pending), 32'b0100);
        bus.req_in = 4'b0101;
        repeat (2) tick();
        bus.res_done = 1'b1;
        tick();
        bus.res_done = 1'b0;
        check("gc_idle_ovr", 32'(bus.overrun), 32'd0);
        tick();
        check("gc_trig", 32'(bus.trigger_out), 32'd1);
        check("gc_id", 32'(bus.grant_id), 32'd2);
        check("gc_repend", 32'(bus.pending), 32'b0100);
        check("gc_no_ovr", 32'(bus.overrun), 32'd0);
        do_grant("gc_g1", 2, 0);
        do_grant("gc_g2", 2, 0);

        // Early done during PULSE: pulse keeps its width, WAIT lasts one cycle.
        reset_dut(4'b0000);
        bus.req_in = 4'b1000;
        n = 0;
        while (!bus.trigger_out && n < 100) begin
            tick();
            n++;
        end
        check("ed_id", 32'(bus.grant_id), 32'd3);
        hi = 0;
        while (bus.trigger_out && hi < 50) begin
            hi++;
            bus.res_done = (hi == 2);
            tick();
        end
        bus.res_done = 1'b0;
        check("ed_width", 32'(hi), 32'(PULSE_LEN));
        check("ed_wait_gv", 32'(bus.grant_valid), 32'd1);
        tick();
        check("ed_idle_gv", 32'(bus.grant_valid), 32'd0);

        // Reset in the second PULSE cycle; afterwards the search restarts at requester 0.
        reset_dut(4'b0000);
        bus.req_in = 4'b0010;
        repeat (2) tick();
        bus.req_in = 4'b1010;
        repeat (3) tick();
        check("mr_id", 32'(bus.grant_id), 32'd1);
        tick();
        check("mr_pend_pre", 32'(bus.pending), 32'b1000);
        reset = 1'b0;
        #1;
        check("mr_trig", 32'(bus.trigger_out), 32'd0);
        check("mr_gv", 32'(bus.grant_valid), 32'd0);
        check("mr_pend", 32'(bus.pending), 32'd0);
        reset_dut(4'b1111);
        do_grant("mr_first", 0, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/trigger_scheduler.md
# trigger_scheduler

Shares one pulse-triggered resource (ADC conversion start / UART frame send) between N_REQ asynchronous trigger sources on the portable UART board. Each source's rising edge becomes a sticky pending request. A round-robin FSM grants one request at a time, issues a fixed-width high pulse on the shared trigger line, and waits for the resource's done strobe or a timeout before granting again. It sits between the raw trigger inputs and the shared resource, in the clk_core domain.

## Interface
- N_REQ, 4: number of requesters, 2..8
- PULSE_LEN, 4: trigger_out high time in clk_core cycles, 1..15
- TIMEOUT, 255: maximum WAIT cycles before abort, 1..255
- SYNC_STAGES, 2: synchronizer flops per request input, ≥2
- clk_core  input  1  core clock; the only clock
- reset  input  1  asynchronous, active-low reset
- req_in  input  N_REQ  asynchronous request levels; a rising edge is a request
- res_done  input  1  one-cycle done strobe from the shared resource
- trigger_out  output  1  registered pulse to the shared resource
- grant_valid  output  1  high while a grant is in progress (PULSE or WAIT)
- grant_id  output  clog2(N_REQ)  index of the granted requester
- pending  output  N_REQ  sticky pending-request bits
- overrun  output  1  one-cycle pulse when an edge arrives on an already-pending requester
- timeout_err  output  1  one-cycle pulse when WAIT expires without res_done
- debug_out  output  1  equals trigger_out

## Operation
- Reset (reset=0, asynchronous) forces every output and register to 0:
  - trigger_out, grant_valid, grant_id, pending, overrun, timeout_err
  - synchronizers, state=IDLE, last_grant=N_REQ-1
- Edge detect, per requester:
  - req_in passes through SYNC_STAGES flops, then one history flop.
  - A rise is sync=1 while hist=0, for one cycle.
  - A rise sets pending[i] in the next cycle.
  - A rise while pending[i]=1 leaves pending unchanged and pulses overrun.
- FSM states: IDLE, PULSE, WAIT.
- IDLE:
  - If pending≠0, select the first set bit searching last_grant+1, last_grant+2, … with wrap-around.
  - Next cycle: grant_id=sel, last_grant=sel, pending[sel] cleared, grant_valid=1, trigger_out=1, counter=0, state=PULSE.
- PULSE:
  - trigger_out stays 1 and the counter increments.
  - When counter=PULSE_LEN-1, the next cycle has trigger_out=0, counter=0, state=WAIT.
- WAIT:
  - res_done=1 → IDLE and grant_valid=0 next cycle.
  - Otherwise the counter increments.
  - When counter=TIMEOUT-1 without res_done → timeout_err pulse, IDLE, grant_valid=0.
- res_done during PULSE is latched into done_seen. WAIT then exits to IDLE in its first cycle. done_seen clears on entering IDLE.
- res_done in IDLE is ignored.
- Simultaneous events:
  - A set and a clear of the same pending bit in one cycle: the set wins, so the request is kept and no overrun is raised.
  - A rise on the requester currently being granted in the same cycle also sets pending.
- Reset asserted mid-PULSE drops trigger_out asynchronously; any truncated pulse is acceptable.

## Timing
- Rising edge on req_in (setup met at cycle 0) → pending set at cycle SYNC_STAGES+2.
- Pending visible in IDLE at cycle t → trigger_out=1 on cycles t+1 … t+PULSE_LEN.
- Back-to-back service: the minimum period between pulses is PULSE_LEN+2 cycles (PULSE, ≥1 WAIT, IDLE).
- grant_id is stable from the PULSE entry until the cycle after leaving WAIT. It keeps its last value in IDLE.
- overrun and timeout_err are single-cycle and registered.

## Structure
- Shared package trigger_pkg holds:
  - state encodings IDLE=2'd0, PULSE=2'd1, WAIT=2'd2
  - default PULSE_LEN and TIMEOUT constants, also reused by other pulse blocks
- Sub-module edge_sync: one requester's synchronizer plus rise detect. It is instantiated N_REQ times.
- The round-robin selector stays inline as a combinational function.

## Test plan
- Single request, N_REQ=4, PULSE_LEN=4: rise on req_in[2] → pending[2] at +4, trigger_out high exactly 4 cycles, grant_id=2; res_done 3 cycles later → grant_valid low next cycle.
- Fairness: all four req_in rise together, res_done returned 2 cycles into each WAIT → grant order 0,1,2,3; a new rise on 0 during the 3 grant → grant 0 next.
- Timeout, TIMEOUT=10: no res_done → timeout_err pulses once, 10 cycles after WAIT entry; the FSM returns to IDLE and serves the next pending request.
- Overrun: second rise on req_in[1] while pending[1]=1 → overrun one cycle, one grant only. A rise on the requester exactly at its grant cycle → pending re-set and no overrun.
- Early done: res_done during PULSE → WAIT lasts 1 cycle, then IDLE.
- Mid-operation reset: reset=0 in the 2nd PULSE cycle → trigger_out, grant_valid and pending are 0 immediately. After release, the first grant starts from requester 0.
